// File: rtl/muldiv_hilo_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_hilo_pkg
//   Shared definitions for the HI/LO multiply/divide unit: the request opcode
//   encoding and small classification helpers used by both the datapath and
//   anything that issues requests to it.
// ---------------------------------------------------------------------------
package muldiv_hilo_pkg;

    typedef enum logic [3:0] {
        NOP   = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MADD  = 4'd5,
        MADDU = 4'd6,
        MSUB  = 4'd7,
        MSUBU = 4'd8,
        MTHI  = 4'd9,
        MTLO  = 4'd10
    } md_op_t;

    // Ops that go through the multiplier pipeline (plain or accumulating).
    function automatic logic is_mul_class(input md_op_t op);
        return op inside {MULT, MULTU, MADD, MADDU, MSUB, MSUBU};
    endfunction

    // Ops that go through the iterative divider.
    function automatic logic is_div_class(input md_op_t op);
        return op inside {DIV, DIVU};
    endfunction

    // Operands are two's complement for these ops.
    function automatic logic is_signed_op(input md_op_t op);
        return op inside {MULT, DIV, MADD, MSUB};
    endfunction

    // Result is folded into the existing {hi,lo} rather than replacing it.
    function automatic logic is_acc_op(input md_op_t op);
        return op inside {MADD, MADDU, MSUB, MSUBU};
    endfunction

    // Accumulate by subtraction.
    function automatic logic is_sub_op(input md_op_t op);
        return op inside {MSUB, MSUBU};
    endfunction

endpackage

// File: rtl/muldiv_hilo_div_iter.sv
// ---------------------------------------------------------------------------
// muldiv_hilo_div_iter
//   Unsigned radix-2 restoring divider. One quotient bit per clock; the first
//   bit is produced on the start edge itself, so the done pulse is high in the
//   cycle WIDTH cycles after the start cycle.
//
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   start         load dividend/divisor and perform the first iteration
//   kill          abandon any division in progress (wins over start)
//   dividend      unsigned dividend magnitude (sampled with start)
//   divisor       unsigned divisor magnitude (sampled with start)
//   quotient      quotient, valid while done is high
//   remainder     remainder, valid while done is high
//   done          one-cycle pulse when quotient/remainder are final
// ---------------------------------------------------------------------------
module muldiv_hilo_div_iter
    import muldiv_hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             kill,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_p1;
    logic [WIDTH-1:0] quo_p1;
    logic [WIDTH-1:0] dvs_p1;
    logic [CW-1:0]    cnt;
    logic             run;

    // One restoring step. quo holds the not-yet-consumed dividend bits in its
    // upper part and the quotient bits produced so far in its lower part.
    // The trial difference is one bit wider than the operands so its top bit
    // is the borrow: clear means the divisor fitted.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                    input logic [WIDTH-1:0] quo,
                                                    input logic [WIDTH-1:0] dvs);
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] diff;
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        if (!diff[WIDTH])
            return {diff[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
        else
            return {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
    endfunction

    // ---- iteration stage: start edge does step 1, then one step per clock ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_p1 <= '0;
            quo_p1 <= '0;
            dvs_p1 <= '0;
            cnt    <= '0;
            run    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                run <= 1'b0;
                cnt <= '0;
            end else if (start) begin
                {rem_p1, quo_p1} <= div_step('0, dividend, divisor);
                dvs_p1           <= divisor;
                cnt              <= CW'(WIDTH - 1);
                run              <= 1'b1;
            end else if (run) begin
                {rem_p1, quo_p1} <= div_step(rem_p1, quo_p1, dvs_p1);
                cnt              <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient  = quo_p1;
    assign remainder = rem_p1;

endmodule

// File: rtl/muldiv_hilo.sv
// ---------------------------------------------------------------------------
// muldiv_hilo
//   HI/LO register pair with a pipelined multiplier (MULT/MULTU and the
//   MADD/MSUB accumulate family) and an iterative divider (DIV/DIVU).
//   MTHI/MTLO write a single register in the accept cycle. A flush abandons
//   any in-flight op without touching HI/LO and blocks same-cycle requests.
//
// Parameters:
//   WIDTH     operand and HI/LO width (product/accumulator is 2*WIDTH)
//   MUL_LAT   multiply-class latency in cycles, 1..4
//
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   req_valid     request present
//   req_ready     request accepted when req_valid && req_ready at an edge
//   req_op        operation (md_op_t)
//   req_a, req_b  rs/rt operands (dividend/divisor for divide)
//   flush         abort in-flight op and refuse any same-cycle request
//   busy          multi-cycle op in flight
//   done          one-cycle pulse when a multi-cycle result first shows
//   hi, lo        HI and LO registers
// ---------------------------------------------------------------------------
module muldiv_hilo
    import muldiv_hilo_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  md_op_t           req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] mul_cnt;
    logic             div_setup;
    logic             accept;

    md_op_t           op_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;

    assign busy      = (state != ST_IDLE);
    assign req_ready = !busy && !flush;
    assign accept    = req_valid && req_ready;

    // Two's complement negate when neg is set; used for magnitudes and for
    // restoring the signs of the divider outputs.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
        return neg ? -v : v;
    endfunction

    // ---- stage p0: operands captured at acceptance, product formed combinationally ----
    // Sign- or zero-extending to 2*WIDTH lets one modular multiply serve both
    // the signed and unsigned ops; the low 2*WIDTH bits are exact either way.
    logic                       mul_sgn;
    logic signed [2*WIDTH-1:0] ma_p0;
    logic signed [2*WIDTH-1:0] mb_p0;
    logic signed [2*WIDTH-1:0] prod_p0;
    logic        [2*WIDTH-1:0] prod_fin;
    logic        [2*WIDTH-1:0] mul_res;

    assign mul_sgn = is_signed_op(op_p0);
    assign ma_p0   = {{WIDTH{mul_sgn & a_p0[WIDTH-1]}}, a_p0};
    assign mb_p0   = {{WIDTH{mul_sgn & b_p0[WIDTH-1]}}, b_p0};
    assign prod_p0 = ma_p0 * mb_p0;

    // ---- stages p1..p(MUL_LAT-1): product retiming shift ----
    if (MUL_LAT == 1) begin : g_mul_nopipe
        assign prod_fin = prod_p0;
    end else begin : g_mul_pipe
        logic [2*WIDTH-1:0] prod_pipe [MUL_LAT-1];

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                for (int i = 0; i < MUL_LAT - 1; i++) prod_pipe[i] <= '0;
            end else begin
                prod_pipe[0] <= prod_p0;
                for (int i = 1; i < MUL_LAT - 1; i++) prod_pipe[i] <= prod_pipe[i-1];
            end
        end

        assign prod_fin = prod_pipe[MUL_LAT-2];
    end

    // HI/LO cannot change while busy, so the live pair is the acceptance-time
    // value the accumulate ops are defined against.
    assign mul_res = !is_acc_op(op_p0) ? prod_fin :
                     is_sub_op(op_p0)  ? ({hi, lo} - prod_fin) :
                                         ({hi, lo} + prod_fin);

    // ---- divide: magnitudes feed the iterator, signs restored on the way out ----
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;
    logic             div_done;
    logic             div_by_zero;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;

    assign a_neg = is_signed_op(op_p0) & a_p0[WIDTH-1];
    assign b_neg = is_signed_op(op_p0) & b_p0[WIDTH-1];
    assign a_mag = cond_neg(a_p0, a_neg);
    assign b_mag = cond_neg(b_p0, b_neg);

    muldiv_hilo_div_iter #(
        .WIDTH (WIDTH)
    ) u_div_iter (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_setup),
        .kill      (flush),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (div_q),
        .remainder (div_r),
        .done      (div_done)
    );

    // Quotient truncates toward zero, remainder follows the dividend's sign.
    // MIN / -1 needs no special case: the magnitude quotient 2^(WIDTH-1)
    // re-reads as MIN and the remainder is zero.
    assign div_by_zero = (b_p0 == '0);
    assign div_hi      = div_by_zero ? a_p0 : cond_neg(div_r, a_neg);
    assign div_lo      = div_by_zero ? '1   : cond_neg(div_q, a_neg ^ b_neg);

    // ---- control and HI/LO write-back ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            mul_cnt   <= '0;
            div_setup <= 1'b0;
            op_p0     <= NOP;
            a_p0      <= '0;
            b_p0      <= '0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_p0   <= req_op;
                        a_p0    <= req_a;
                        b_p0    <= req_b;
                        mul_cnt <= '0;
                        if (is_mul_class(req_op)) begin
                            state <= ST_MUL;
                        end else if (is_div_class(req_op)) begin
                            state     <= ST_DIV;
                            div_setup <= 1'b1;
                        end else if (req_op == MTHI) begin
                            hi <= req_a;
                        end else if (req_op == MTLO) begin
                            lo <= req_a;
                        end
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (mul_cnt == MUL_LAST) begin
                        {hi, lo} <= mul_res;
                        done     <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        mul_cnt <= mul_cnt + CNT_W'(1);
                    end
                end
                ST_DIV: begin
                    div_setup <= 1'b0;
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (div_done) begin
                        hi    <= div_hi;
                        lo    <= div_lo;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
